vc_scheduler: RTL

VC_SCHEDULER -- requirements
Module: vc_scheduler

---
 rtl/pcie_pkg.sv | 22 ++
 rtl/vc_flow_ctrl.sv | 48 ++++
 rtl/vc_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/pcie_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pcie_pkg : shared encodings for the VC scheduler slice          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package pcie_pkg;

  localparam logic [1:0] C_ARB_IDLE      = 2'd0;
  localparam logic [1:0] C_ARB_SERVE_VC0 = 2'd1;
  localparam logic [1:0] C_ARB_SERVE_VC1 = 2'd2;
  localparam logic [1:0] C_ARB_STALL     = 2'd3;

  localparam logic C_FLOW_RUN  = 1'b0;
  localparam logic C_FLOW_HOLD = 1'b1;

  localparam logic C_VC0 = 1'b0;
  localparam logic C_VC1 = 1'b1;

  localparam int C_THRESH_W = 4;

endpackage
`default_nettype wire

// File: rtl/vc_flow_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vc_flow_ctrl : per-VC RUN/HOLD pause / continue generator       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module vc_flow_ctrl
  import pcie_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [C_THRESH_W-1:0] umbral_a,
  input  logic [C_THRESH_W-1:0] umbral_b,
  input  logic [CNT_W-1:0]      count,
  output logic                  pause,
  output logic                  cont
);

  localparam int W = (CNT_W > C_THRESH_W) ? CNT_W : C_THRESH_W;

  logic         r_state;
  logic [W-1:0] w_cnt;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;

  assign w_cnt = W'(count);
  assign w_a   = W'(umbral_a);
  assign w_b   = W'(umbral_b);

  // Release is tested only from HOLD, so overlapping thresholds let it win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= C_FLOW_RUN;
      cont    <= 1'b0;
    end else if (r_state == C_FLOW_HOLD) begin
      cont <= (w_cnt <= w_b);
      if (w_cnt <= w_b) r_state <= C_FLOW_RUN;
    end else begin
      cont <= 1'b0;
      if ((w_a != '0) && (w_cnt >= w_a)) r_state <= C_FLOW_HOLD;
    end
  end

  assign pause = (r_state == C_FLOW_HOLD);

endmodule
`default_nettype wire

// File: rtl/vc_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vc_scheduler : two-VC pop arbiter with VC0 burst limit and flow |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module vc_scheduler
  import pcie_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int BUS_SIZE   = 5,
  parameter int VC0_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [C_THRESH_W-1:0] umbralA,
  input  logic [C_THRESH_W-1:0] umbralB,
  input  logic [ADDR_WIDTH:0]   vc0_count,
  input  logic [ADDR_WIDTH:0]   vc1_count,
  input  logic [BUS_SIZE:0]     vc0_data,
  input  logic [BUS_SIZE:0]     vc1_data,
  input  logic                  dest_pause,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic [BUS_SIZE-1:0]   data_out,
  output logic                  valid_out,
  output logic                  pause_VC0,
  output logic                  pause_VC1,
  output logic                  continue_VC0,
  output logic                  continue_VC1
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int BW = $clog2(VC0_BURST + 1);
  localparam logic [BW-1:0] C_BURST_MAX = BW'(VC0_BURST);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [BW-1:0] r_burst;
  logic [BW-1:0] w_burst_next;
  logic          r_started;
  logic          r_inflight;
  logic          r_sel_d;
  logic          w_has0;
  logic          w_has1;
  logic          w_unused;

  // Occupancy net of the pop already on the wire, so back-to-back pops never underflow.
  assign w_has0 = vc0_count > CW'(pop_vc0);
  assign w_has1 = vc1_count > CW'(pop_vc1);

  assign w_unused = ^{vc0_data[BUS_SIZE], vc1_data[BUS_SIZE]};

  always_comb begin
    w_next = C_ARB_IDLE;
    if (!r_started)
      w_next = C_ARB_IDLE;
    else if (dest_pause)
      w_next = C_ARB_STALL;
    else if (w_has0 && (!w_has1 || (r_burst < C_BURST_MAX)))
      w_next = C_ARB_SERVE_VC0;
    else if (w_has1)
      w_next = C_ARB_SERVE_VC1;
  end

  always_comb begin
    w_burst_next = r_burst;
    if (!w_has1 || (w_next == C_ARB_SERVE_VC1))
      w_burst_next = '0;
    else if ((w_next == C_ARB_SERVE_VC0) && (r_burst != C_BURST_MAX))
      w_burst_next = r_burst + BW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_started  <= 1'b0;
      r_state    <= C_ARB_IDLE;
      r_burst    <= '0;
      pop_vc0    <= 1'b0;
      pop_vc1    <= 1'b0;
      r_inflight <= 1'b0;
      r_sel_d    <= C_VC0;
      valid_out  <= 1'b0;
      data_out   <= '0;
    end else begin
      r_started  <= 1'b1;
      r_state    <= w_next;
      r_burst    <= w_burst_next;
      pop_vc0    <= (w_next == C_ARB_SERVE_VC0);
      pop_vc1    <= (w_next == C_ARB_SERVE_VC1);
      r_inflight <= pop_vc0 | pop_vc1;
      r_sel_d    <= (r_state == C_ARB_SERVE_VC1) ? C_VC1 : C_VC0;
      valid_out  <= r_inflight;
      if (r_inflight)
        data_out <= (r_sel_d == C_VC1) ? vc1_data[BUS_SIZE-1:0] : vc0_data[BUS_SIZE-1:0];
    end
  end

  vc_flow_ctrl #(.CNT_W(CW)) u_flow_vc0 (
    .clk      (clk),
    .reset    (reset),
    .umbral_a (umbralA),
    .umbral_b (umbralB),
    .count    (vc0_count),
    .pause    (pause_VC0),
    .cont     (continue_VC0)
  );

  vc_flow_ctrl #(.CNT_W(CW)) u_flow_vc1 (
    .clk      (clk),
    .reset    (reset),
    .umbral_a (umbralA),
    .umbral_b (umbralB),
    .count    (vc1_count),
    .pause    (pause_VC1),
    .cont     (continue_VC1)
  );

endmodule
`default_nettype wire
